// File: rtl/dmem_arbiter.sv
// Two-requester (pipeline / debug) arbiter and sequencer for the single-port data memory.
// Optional ALIGN_CHECK_EN adds p_err/d_err and short-circuits misaligned accesses.
module dmem_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [63:0] p_addr,
  input  logic [63:0] p_wdata,
  output logic [63:0] p_rdata,
  output logic        p_done,
  output logic        p_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic [63:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
`ifdef ALIGN_CHECK_EN
  output logic        p_err,
  output logic        d_err,
`endif
  output logic        busy
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] streak;
  logic          owner;              // 1 = debug owns the current access
  logic          lat_we;
  logic [63:0]   lat_addr, lat_wdata;
  logic          any_req, pick_d, sel_we, misal;
  logic [63:0]   sel_addr, sel_wdata;

  // Debug wins alone, or when the pipeline has used up its streak.
  assign any_req   = p_req | d_req;
  assign pick_d    = d_req & (~p_req | (streak == SW'(MAX_STREAK)));
  assign sel_we    = pick_d ? d_we    : p_we;
  assign sel_addr  = pick_d ? d_addr  : p_addr;
  assign sel_wdata = pick_d ? d_wdata : p_wdata;
`ifdef ALIGN_CHECK_EN
  assign misal = |sel_addr[2:0];
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (any_req) begin
        state_nxt = misal ? DONE : ACCESS;
        cnt_nxt   = CW'(LATENCY - 1);
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak    <= '0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE) begin
      if (!d_req)
        streak <= '0;
      else if (p_req && !pick_d)
        streak <= (streak == SW'(MAX_STREAK)) ? streak : streak + SW'(1);
      else
        streak <= '0;
      if (any_req) begin
        owner     <= pick_d;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
    end
  end

  // Load data lands on the final access cycle; a misaligned grant zeroes the owner's register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_rdata <= '0;
      d_rdata <= '0;
    end else if (state == ACCESS && cnt == '0 && !lat_we) begin
      if (owner) d_rdata <= mem_rdata;
      else       p_rdata <= mem_rdata;
    end else if (state == IDLE && any_req && misal) begin
      if (pick_d) d_rdata <= '0;
      else        p_rdata <= '0;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic err_r;
  always_ff @(posedge clk) begin
    if (reset)                         err_r <= 1'b0;
    else if (state == IDLE && any_req) err_r <= misal;
  end
  assign p_err = (state == DONE) & ~owner & err_r;
  assign d_err = (state == DONE) &  owner & err_r;
`endif

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_re    = (state == ACCESS) & ~lat_we;
  assign mem_we    = (state == ACCESS) & lat_we & (cnt == '0);
  assign p_done    = (state == DONE) & ~owner;
  assign d_done    = (state == DONE) &  owner;
  assign busy      = (state != IDLE);
  assign p_stall   = p_req & ~p_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LATENCY=2 instance with a memory model, plus a LATENCY=1 instance.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we, d_req, d_we;
  logic [63:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [63:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        p_done, p_stall, d_done, mem_re, mem_we, busy;
  logic        p_err_w, d_err_w;

  logic        q_req;
  logic [63:0] q_addr, q_rdata, q_d_rdata, q_maddr, q_mwdata, q_mrdata;
  logic        q_done, q_stall, q_d_done, q_mre, q_mwe, q_busy;
  logic        q_p_err, q_d_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.LATENCY(2), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ALIGN_CHECK_EN
    .p_err(p_err_w), .d_err(d_err_w),
`endif
    .busy(busy)
  );

  dmem_arbiter #(.LATENCY(1), .MAX_STREAK(4)) u1 (
    .clk(clk), .reset(reset),
    .p_req(q_req), .p_we(1'b0), .p_addr(q_addr), .p_wdata(64'd0),
    .p_rdata(q_rdata), .p_done(q_done), .p_stall(q_stall),
    .d_req(1'b0), .d_we(1'b0), .d_addr(64'd0), .d_wdata(64'd0),
    .d_rdata(q_d_rdata), .d_done(q_d_done),
    .mem_addr(q_maddr), .mem_re(q_mre), .mem_we(q_mwe),
    .mem_wdata(q_mwdata), .mem_rdata(q_mrdata),
`ifdef ALIGN_CHECK_EN
    .p_err(q_p_err), .d_err(q_d_err),
`endif
    .busy(q_busy)
  );

`ifndef ALIGN_CHECK_EN
  assign p_err_w = 1'b0;
  assign d_err_w = 1'b0;
  assign q_p_err = 1'b0;
  assign q_d_err = 1'b0;
`endif

  assign mem_rdata = mem[mem_addr[10:3]];
  always @(posedge clk) if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;
  assign q_mrdata = {q_maddr[31:0], 32'hCAFE0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access from the chosen port; i counts cycles after the grant edge.
  task automatic xfer(input bit dbg, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                      output int dcyc, output int nwe, output int wecyc, output int nre,
                      output int xdone, output logic [63:0] rd, output logic stall_done,
                      output logic err);
    dcyc = -1; nwe = 0; wecyc = -1; nre = 0; xdone = 0; rd = '0; stall_done = 1'b1; err = 1'b0;
    @(negedge clk);
    if (dbg) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else     begin p_req = 1; p_we = we; p_addr = addr; p_wdata = wdata; end
    for (int i = 1; i <= 20 && dcyc < 0; i++) begin
      @(negedge clk);
      if (mem_we) begin nwe++; wecyc = i; end
      if (mem_re) nre++;
      if (dbg ? p_done : d_done) xdone++;
      if (dbg ? d_done : p_done) begin
        dcyc = i;
        rd = dbg ? d_rdata : p_rdata;
        stall_done = p_stall;
        err = dbg ? d_err_w : p_err_w;
      end
    end
    p_req = 0; d_req = 0;
  endtask

  int dcyc, nwe, wecyc, nre, xdone;
  logic [63:0] rd;
  logic sd, er;

  initial begin
    logic [9:0] seq;
    int n, bad_stall;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1; p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; q_req = 0; q_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pdone", p_done, 0);
    chk("rst_mem_re_we", {mem_re, mem_we}, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;

    // Pipeline store then load
    xfer(0, 1, 64'h40, 64'hDEADBEEF, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("st_done_cyc", dcyc, 3);
    chk("st_nwe", nwe, 1);
    chk("st_we_cyc", wecyc, 2);
    chk("st_mem", mem[8], 64'hDEADBEEF);
    xfer(0, 0, 64'h40, 64'h0, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("ld_done_cyc", dcyc, 3);
    chk("ld_rdata", rd, 64'hDEADBEEF);
    chk("ld_stall_at_done", sd, 0);
    chk("ld_nre", nre, 2);
    chk("ld_nwe", nwe, 0);

    // Debug write, pipeline readback
    xfer(1, 1, 64'h80, 64'h1234, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("dbg_done_cyc", dcyc, 3);
    chk("dbg_no_pdone", xdone, 0);
    chk("dbg_nwe", nwe, 1);
    xfer(0, 0, 64'h80, 64'h0, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("dbg_readback", rd, 64'h1234);
    chk("p_no_ddone", xdone, 0);

    // Both requesting continuously: 4 pipeline grants, then 1 debug
    @(negedge clk);
    p_req = 1; p_we = 0; p_addr = 64'h40; d_req = 1; d_we = 0; d_addr = 64'h80;
    seq = '0; n = 0; bad_stall = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (d_done && !p_stall) bad_stall++;
      if (p_done && d_done) bad_stall++;
      if (d_done) seq[n] = 1'b1;
      if (p_done || d_done) n++;
    end
    p_req = 0; d_req = 0;
    chk("arb_count", n, 10);
    chk("arb_pattern", seq, 10'h210);
    chk("arb_stall", bad_stall, 0);
    chk("arb_d_rdata", d_rdata, 64'h1234);

    // Reset during first ACCESS cycle of a store
    @(negedge clk);
    @(negedge clk);
    p_req = 1; p_we = 1; p_addr = 64'h100; p_wdata = 64'h5555;
    @(negedge clk);
    chk("rma_busy", busy, 1);
    chk("rma_we_first", mem_we, 0);
    reset = 1; p_req = 0;
    @(negedge clk);
    chk("rma_busy_after", busy, 0);
    chk("rma_we_after", mem_we, 0);
    chk("rma_done", p_done, 0);
    chk("rma_p_rdata", p_rdata, 0);
    chk("rma_d_rdata", d_rdata, 0);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rma_idle", {busy, mem_we, p_done}, 0);
    end
    chk("rma_mem", mem[32], 0);

    // LATENCY=1 load
    q_req = 1; q_addr = 64'h88;
    @(negedge clk);
    chk("l1_re", q_mre, 1);
    chk("l1_busy", q_busy, 1);
    @(negedge clk);
    chk("l1_done", q_done, 1);
    chk("l1_rdata", q_rdata, 64'h00000088_CAFE0000);
    q_req = 0;
    @(negedge clk);
    chk("l1_idle", {q_busy, q_done}, 0);

`ifdef ALIGN_CHECK_EN
    xfer(0, 0, 64'h40, 64'h0, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("al_ok_rdata", rd, 64'hDEADBEEF);
    chk("al_ok_err", er, 0);
    xfer(0, 0, 64'h43, 64'h0, dcyc, nwe, wecyc, nre, xdone, rd, sd, er);
    chk("al_done_cyc", dcyc, 1);
    chk("al_nre_nwe", nre + nwe, 0);
    chk("al_err", er, 1);
    chk("al_rdata", rd, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
